// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with phase offsets and lock indication.
// All channels are resynchronised and relocked on every accepted reconfiguration.
module clk_div_gen #(
  parameter int NUM_CLOCKS  = 2,
  parameter int DIV_WIDTH   = 16,
  parameter int DIV_INIT    = 50,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_chan,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [DIV_WIDTH-1:0]  cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] tick,
  output logic                  locked
);

  localparam int LW =
    (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_LAST =
    LW'(LOCK_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_ONE = LW'(1);
  localparam logic [DIV_WIDTH-1:0] ONE =
    DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO =
    DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DIV_RST =
    DIV_WIDTH'(DIV_INIT);

  typedef enum logic {
    S_LOCKING,
    S_LOCKED
  } state_e;

  state_e state_q, state_d;

  logic [LW-1:0] lock_q, lock_d;
  logic locked_q, locked_d;
  logic ready_q, ready_d;
  logic [NUM_CLOCKS-1:0] outclk_q, outclk_d;
  logic [NUM_CLOCKS-1:0] tick_q, tick_d;

  logic [DIV_WIDTH-1:0] div_q [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] div_d [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] ph_q  [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] ph_d  [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] cnt_q [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] cnt_d [NUM_CLOCKS];

  logic accept;
  logic chan_ok;
  logic hit;
  logic [DIV_WIDTH-1:0] new_div;
  logic [DIV_WIDTH-1:0] new_ph;
  logic [NUM_CLOCKS-1:0] wrap;

  // Out-of-range channels complete the handshake with no effect.
  assign accept  = cfg_valid & ready_q;
  assign chan_ok = {1'b0, cfg_chan} < 5'(NUM_CLOCKS);
  assign hit     = accept & chan_ok;

  assign new_div =
    (cfg_div < TWO) ? TWO : cfg_div;
  assign new_ph =
    (cfg_phase < new_div) ? cfg_phase : '0;

  always_comb begin
    wrap = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      wrap[i] = (cnt_q[i] == (div_q[i] - ONE));
    end
  end

  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    locked_d = locked_q;
    ready_d  = ready_q;
    outclk_d = '0;
    tick_d   = '0;
    div_d    = div_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_LOCKING: begin
        lock_d = lock_q + LOCK_ONE;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
          cnt_d[i] = ph_q[i];
        end
        if (lock_q == LOCK_LAST) begin
          state_d  = S_LOCKED;
          lock_d   = '0;
          locked_d = 1'b1;
          ready_d  = 1'b1;
        end
      end
      S_LOCKED: begin
        if (hit) begin
          for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (cfg_chan == 4'(i)) begin
              div_d[i] = new_div;
              ph_d[i]  = new_ph;
              cnt_d[i] = new_ph;
            end else begin
              cnt_d[i] = ph_q[i];
            end
          end
          state_d  = S_LOCKING;
          lock_d   = '0;
          locked_d = 1'b0;
          ready_d  = 1'b0;
        end else begin
          for (int i = 0; i < NUM_CLOCKS; i++) begin
            cnt_d[i] =
              wrap[i] ? '0 : cnt_q[i] + ONE;
            outclk_d[i] =
              (cnt_q[i] < (div_q[i] >> 1));
            tick_d[i] = wrap[i];
          end
        end
      end
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOCKING;
      lock_q   <= '0;
      locked_q <= 1'b0;
      ready_q  <= 1'b0;
      outclk_q <= '0;
      tick_q   <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i] <= DIV_RST;
        ph_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      locked_q <= locked_d;
      ready_q  <= ready_d;
      outclk_q <= outclk_d;
      tick_q   <= tick_d;
      div_q    <= div_d;
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cfg_ready = ready_q;
  assign locked    = locked_q;
  assign outclk    = outclk_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: closed-form period/phase reference model,
// directed scenarios plus randomized reconfiguration traffic.
module tb_clk_div_gen;

  localparam int NC = 2;
  localparam int DW = 16;
  localparam int DI = 50;
  localparam int L  = 16;

  logic          refclk;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [3:0]    cfg_chan;
  logic [DW-1:0] cfg_div;
  logic [DW-1:0] cfg_phase;
  logic [NC-1:0] outclk;
  logic [NC-1:0] tick;
  logic          locked;

  int n_checks = 0;
  int n_pass   = 0;

  clk_div_gen #(
    .NUM_CLOCKS (NC),
    .DIV_WIDTH  (DW),
    .DIV_INIT   (DI),
    .LOCK_CYCLES(L)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .outclk   (outclk),
    .tick     (tick),
    .locked   (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Reference model: n counts edges since reset, start is the edge
  // that began the current lock sequence.
  int n;
  int start;
  int m_acc = 0;
  int m_div [NC];
  int m_ph  [NC];

  function automatic int clamp_div(int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int clamp_ph(int p, int d);
    return (p < clamp_div(d)) ? p : 0;
  endfunction

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      n     <= 0;
      start <= 0;
      for (int i = 0; i < NC; i++) begin
        m_div[i] <= DI;
        m_ph[i]  <= 0;
      end
    end else begin
      n <= n + 1;
      if (cfg_valid && (n >= start + L)
          && int'(cfg_chan) < NC) begin
        for (int i = 0; i < NC; i++) begin
          if (int'(cfg_chan) == i) begin
            m_div[i] <= clamp_div(int'(cfg_div));
            m_ph[i]  <= clamp_ph(int'(cfg_phase),
                                 int'(cfg_div));
          end
        end
        start <= n + 1;
        m_acc <= m_acc + 1;
      end
    end
  end

  function automatic logic m_locked();
    return n >= start + L;
  endfunction

  // {locked, cfg_ready, tick, outclk}
  function automatic logic [2*NC+1:0] exp_bundle();
    logic [NC-1:0] oc;
    logic [NC-1:0] tk;
    int k;
    int c;
    oc = '0;
    tk = '0;
    if (n >= start + L + 1) begin
      k = n - start - L - 1;
      for (int i = 0; i < NC; i++) begin
        c = (m_ph[i] + k) % m_div[i];
        oc[i] = (c < m_div[i] / 2);
        tk[i] = (c == m_div[i] - 1);
      end
    end
    return {m_locked(), m_locked(), tk, oc};
  endfunction

  task automatic cfg_write(int ch, int d, int p);
    cfg_valid = 1'b1;
    cfg_chan  = 4'(ch);
    cfg_div   = DW'(d);
    cfg_phase = DW'(p);
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_model_lock();
    for (int c = 0; c < 3 * L && !m_locked(); c++)
      @(negedge refclk);
  endtask

  task automatic test_reset();
    int first_lock = -1;
    int first_rise = -1;
    int first_tick = -1;
    int ticks = 0;
    int highs = 0;
    rst = 1'b1;
    cfg_valid = 1'b0;
    repeat (3) @(negedge refclk);
    n_checks++;
    if ({locked, cfg_ready, tick, outclk} !== '0)
      $display("FAIL reset_state got %b exp 0",
               {locked, cfg_ready, tick, outclk});
    else n_pass++;
    rst = 1'b0;
    for (int c = 0; c < 130; c++) begin
      @(negedge refclk);
      n_checks++;
      if ({locked, cfg_ready, tick, outclk}
          !== exp_bundle())
        $display("FAIL reset_run n=%0d got %b exp %b", n,
                 {locked, cfg_ready, tick, outclk},
                 exp_bundle());
      else n_pass++;
      if (locked && first_lock < 0) first_lock = n;
      if (outclk[0] && first_rise < 0) first_rise = n;
      if (tick[0] && first_tick < 0) first_tick = n;
      if (tick[0]) ticks++;
      if (outclk[0] && n >= 17 && n <= 66) highs++;
    end
    n_checks++;
    if (first_lock != 16)
      $display("FAIL lock_edge got %0d exp 16", first_lock);
    else n_pass++;
    n_checks++;
    if (first_rise != 17)
      $display("FAIL first_rise got %0d exp 17", first_rise);
    else n_pass++;
    n_checks++;
    if (first_tick != 66)
      $display("FAIL first_tick got %0d exp 66", first_tick);
    else n_pass++;
    n_checks++;
    if (ticks != 2)
      $display("FAIL tick_count got %0d exp 2", ticks);
    else n_pass++;
    n_checks++;
    if (highs != 25)
      $display("FAIL high_time got %0d exp 25", highs);
    else n_pass++;
  endtask

  task automatic test_reconfig();
    int a;
    int relock = -1;
    int t1 = -1;
    int highs = 0;
    wait_model_lock();
    cfg_write(1, 7, 3);
    a = n;
    n_checks++;
    if ({locked, cfg_ready, tick, outclk} !== '0)
      $display("FAIL accept_gate got %b exp 0",
               {locked, cfg_ready, tick, outclk});
    else n_pass++;
    for (int c = 0; c < 60; c++) begin
      @(negedge refclk);
      n_checks++;
      if ({locked, cfg_ready, tick, outclk}
          !== exp_bundle())
        $display("FAIL reconfig n=%0d got %b exp %b", n,
                 {locked, cfg_ready, tick, outclk},
                 exp_bundle());
      else n_pass++;
      if (locked && relock < 0) relock = n;
      if (tick[1] && t1 < 0) t1 = n;
      if (relock > 0 && n > relock && n <= relock + 14
          && outclk[1]) highs++;
    end
    n_checks++;
    if (relock - a != L)
      $display("FAIL relock_delay got %0d exp %0d",
               relock - a, L);
    else n_pass++;
    n_checks++;
    if (t1 - relock != 4)
      $display("FAIL ch1_tick_ofs got %0d exp 4",
               t1 - relock);
    else n_pass++;
    n_checks++;
    if (highs != 6)
      $display("FAIL ch1_high got %0d exp 6", highs);
    else n_pass++;
  endtask

  task automatic test_clamp();
    int a;
    int ticks = 0;
    logic first_hi;
    wait_model_lock();
    cfg_write(0, 0, 0);
    a = n;
    for (int c = 0; c < L + 12; c++) begin
      @(negedge refclk);
      n_checks++;
      if ({locked, cfg_ready, tick, outclk}
          !== exp_bundle())
        $display("FAIL clamp0 n=%0d got %b exp %b", n,
                 {locked, cfg_ready, tick, outclk},
                 exp_bundle());
      else n_pass++;
      if (n > a + L && n <= a + L + 10 && tick[0])
        ticks++;
    end
    n_checks++;
    if (ticks != 5)
      $display("FAIL div0_ticks got %0d exp 5", ticks);
    else n_pass++;
    cfg_write(1, 1, 1);
    for (int c = 0; c < L + 8; c++) begin
      @(negedge refclk);
      n_checks++;
      if ({locked, cfg_ready, tick, outclk}
          !== exp_bundle())
        $display("FAIL clamp1 n=%0d got %b exp %b", n,
                 {locked, cfg_ready, tick, outclk},
                 exp_bundle());
      else n_pass++;
    end
    wait_model_lock();
    cfg_write(1, 5, 9);
    a = n;
    first_hi = 1'b0;
    for (int c = 0; c < L + 12; c++) begin
      @(negedge refclk);
      n_checks++;
      if ({locked, cfg_ready, tick, outclk}
          !== exp_bundle())
        $display("FAIL clamp_ph n=%0d got %b exp %b", n,
                 {locked, cfg_ready, tick, outclk},
                 exp_bundle());
      else n_pass++;
      if (n == a + L + 1) first_hi = outclk[1];
    end
    n_checks++;
    if (first_hi !== 1'b1)
      $display("FAIL phase_clamp got %b exp 1", first_hi);
    else n_pass++;
  endtask

  task automatic test_invalid_chan();
    wait_model_lock();
    cfg_write(5, 3, 1);
    n_checks++;
    if ({locked, cfg_ready} !== 2'b11)
      $display("FAIL bad_chan_lock got %b exp 11",
               {locked, cfg_ready});
    else n_pass++;
    for (int c = 0; c < 40; c++) begin
      n_checks++;
      if ({locked, cfg_ready, tick, outclk}
          !== exp_bundle())
        $display("FAIL bad_chan n=%0d got %b exp %b", n,
                 {locked, cfg_ready, tick, outclk},
                 exp_bundle());
      else n_pass++;
      @(negedge refclk);
    end
  endtask

  task automatic test_reset_mid();
    int first_lock = -1;
    int first_tick = -1;
    wait_model_lock();
    repeat (7) @(negedge refclk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({locked, cfg_ready, tick, outclk} !== '0)
      $display("FAIL rst_mid_run got %b exp 0",
               {locked, cfg_ready, tick, outclk});
    else n_pass++;
    @(negedge refclk);
    rst = 1'b0;
    wait_model_lock();
    cfg_write(0, 9, 2);
    repeat (5) @(negedge refclk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({locked, cfg_ready, tick, outclk} !== '0)
      $display("FAIL rst_mid_lock got %b exp 0",
               {locked, cfg_ready, tick, outclk});
    else n_pass++;
    @(negedge refclk);
    rst = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge refclk);
      n_checks++;
      if ({locked, cfg_ready, tick, outclk}
          !== exp_bundle())
        $display("FAIL rst_relock n=%0d got %b exp %b", n,
                 {locked, cfg_ready, tick, outclk},
                 exp_bundle());
      else n_pass++;
      if (locked && first_lock < 0) first_lock = n;
      if (tick[0] && first_tick < 0) first_tick = n;
    end
    n_checks++;
    if (first_lock != 16 || first_tick != 66)
      $display("FAIL rst_defaults got %0d/%0d exp 16/66",
               first_lock, first_tick);
    else n_pass++;
  endtask

  task automatic test_hold_valid();
    int dut_acc = 0;
    int acc0;
    wait_model_lock();
    acc0 = m_acc;
    cfg_valid = 1'b1;
    cfg_chan  = 4'd0;
    cfg_div   = DW'(4);
    cfg_phase = DW'(1);
    for (int c = 0; c < 3 * (L + 1); c++) begin
      if (cfg_ready) dut_acc++;
      @(negedge refclk);
      n_checks++;
      if ({locked, cfg_ready, tick, outclk}
          !== exp_bundle())
        $display("FAIL hold_valid n=%0d got %b exp %b", n,
                 {locked, cfg_ready, tick, outclk},
                 exp_bundle());
      else n_pass++;
    end
    cfg_valid = 1'b0;
    n_checks++;
    if (dut_acc != 3 || m_acc - acc0 != 3)
      $display("FAIL hold_accepts got %0d exp 3", dut_acc);
    else n_pass++;
  endtask

  task automatic test_random();
    int gap;
    for (int it = 0; it < 30; it++) begin
      gap = $urandom_range(0, 35);
      for (int c = 0; c < gap; c++) begin
        @(negedge refclk);
        n_checks++;
        if ({locked, cfg_ready, tick, outclk}
            !== exp_bundle())
          $display("FAIL random n=%0d got %b exp %b", n,
                   {locked, cfg_ready, tick, outclk},
                   exp_bundle());
        else n_pass++;
      end
      cfg_valid = 1'b1;
      cfg_chan  = 4'($urandom_range(0, 3));
      cfg_div   = DW'($urandom_range(0, 12));
      cfg_phase = DW'($urandom_range(0, 14));
      @(negedge refclk);
      cfg_valid = 1'b0;
      n_checks++;
      if ({locked, cfg_ready, tick, outclk}
          !== exp_bundle())
        $display("FAIL random_cfg n=%0d got %b exp %b", n,
                 {locked, cfg_ready, tick, outclk},
                 exp_bundle());
      else n_pass++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    test_reset();
    test_reconfig();
    test_clamp();
    test_invalid_chan();
    test_reset_mid();
    test_hold_valid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised multi-channel clock generator. Derives NUM_CLOCKS divided clocks and matching one-cycle tick strobes from a single reference clock, with per-channel runtime-programmable divide ratio and phase offset, plus a lock indicator. It replaces fixed-ratio PLL instances where low-frequency, reconfigurable, phase-aligned clock enables are needed, such as ADC sample strobes and UART timing.

## Interface
Parameters:
- NUM_CLOCKS, 2: number of output channels (1..16).
- DIV_WIDTH, 16: width of divide, phase and counter fields.
- DIV_INIT, 50: divide ratio loaded into every channel at reset (50 MHz → 1 MHz).
- LOCK_CYCLES, 16: refclk cycles in LOCKING before `locked` asserts (≥1).

Ports:
- refclk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  reconfiguration request.
- cfg_ready  out  1  high only in LOCKED; a transfer occurs when cfg_valid & cfg_ready.
- cfg_chan  in  4  target channel index.
- cfg_div  in  DIV_WIDTH  new divide ratio.
- cfg_phase  in  DIV_WIDTH  new phase offset, in refclk cycles.
- outclk  out  NUM_CLOCKS  divided clocks, registered.
- tick  out  NUM_CLOCKS  one-cycle strobe per output period, registered.
- locked  out  1  outputs valid and phase-aligned.

## Operation
- Per-channel registers are div_i, ph_i and cnt_i, each DIV_WIDTH bits.
  - Reset values: div_i=DIV_INIT, ph_i=0, cnt_i=0.
- Reset values of outputs: outclk=0, tick=0, locked=0, cfg_ready=0. Reset state is LOCKING with lock counter=0. Reset takes effect immediately, including mid-operation.
- The FSM has two states, LOCKING and LOCKED.
- LOCKING:
  - Counters are held at ph_i.
  - The lock counter increments each cycle.
  - On the edge where lock counter == LOCK_CYCLES-1, the FSM moves to LOCKED; locked<=1 and cfg_ready<=1.
- LOCKED:
  - cnt_i <= (cnt_i == div_i-1) ? 0 : cnt_i+1.
  - outclk_i <= (cnt_i < div_i>>1).
  - tick_i <= (cnt_i == div_i-1).
- Gating: outclk and tick are forced to 0 on any edge where the current state is not LOCKED, and on the edge a config transfer is accepted.
- Config accept (valid & ready, with cfg_chan < NUM_CLOCKS):
  - div[chan] <= max(cfg_div, 2).
  - ph[chan] <= (cfg_phase < clamped div) ? cfg_phase : 0.
  - Every channel's cnt_i is loaded with its phase, using the new value for the target channel. This resynchronises all channels.
  - FSM goes to LOCKING; locked<=0, cfg_ready<=0, lock counter<=0.
- cfg_chan ≥ NUM_CLOCKS: the handshake completes but nothing changes. The FSM stays LOCKED and outputs are not gated.
- Odd divide ratios: high for floor(div/2) cycles, low for ceil(div/2).
- No arithmetic overflow: cnt never exceeds div_i-1 ≤ 2^DIV_WIDTH-2.

## Timing
- After rst deasserts, `locked` rises on the LOCK_CYCLES-th rising edge (edge E).
- outclk_i first rises at edge E+1 when ph_i=0. outclk is high for div_i>>1 cycles per period.
- The first tick occurs at edge E+div_i-ph_i and lasts exactly one cycle.
- With a non-zero phase, a channel's output leads a phase-0 channel by ph_i cycles.
- Reconfig accepted at edge A:
  - locked, cfg_ready, outclk and tick are all 0 after edge A.
  - locked reasserts at edge A+LOCK_CYCLES.
- cfg_ready deasserts on the same edge as an accept, so back-to-back accepts are impossible.

## Test plan
- Reset release with defaults (NUM_CLOCKS=2, DIV_INIT=50, LOCK_CYCLES=16) → locked rises at edge 16; outclk rises at edge 17, high for 25 cycles, period 50; tick at edges 66, 116, ….
- Write chan 1 with div=7, phase=3 → locked low for 16 cycles, then relocks.
  - Ch0: period 50.
  - Ch1: period 7, high 3 / low 4.
  - Ch1 tick occurs 4 cycles after the relock edge.
- cfg_div=0 or 1 → clamped to 2, giving a 1/1 square wave. cfg_phase=9 with div=5 → phase loaded as 0.
- cfg_chan=5 → cfg_ready stays 1, locked stays 1, and outclk is uninterrupted.
- Assert rst mid-period and mid-LOCKING → all outputs 0 immediately; div returns to 50; normal relock sequence follows release.
- Hold cfg_valid high during LOCKING → no accept until cfg_ready=1; exactly one accept occurs per lock cycle.
